// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller: forwarding, load-use stall, branch flush, multiply occupancy.
// Multiply sequencing is built only when HAZARD_MUL_EN is defined.
module hazard_ctrl #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 3,
    parameter int PC_REG  = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   RAD,
    input  logic [NUM_SRC*REG_AW-1:0]   RAE,
    input  logic [REG_AW-1:0]           WA3E,
    input  logic [REG_AW-1:0]           WA3M,
    input  logic [REG_AW-1:0]           WA3W,
    input  logic                        RegWriteE,
    input  logic                        RegWriteM,
    input  logic                        RegWriteW,
    input  logic                        MemtoRegE,
    input  logic                        BranchTakenE,
    input  logic                        MulStartE,
    output logic [2*NUM_SRC-1:0]        ForwardE,
    output logic                        StallF,
    output logic                        StallD,
    output logic                        StallE,
    output logic                        FlushD,
    output logic                        FlushE,
    output logic                        MulBusy,
    output logic                        MulDoneE
);

    localparam logic [REG_AW-1:0] PC_ADDR = PC_REG[REG_AW-1:0];

    logic [2*NUM_SRC-1:0] fwd;
    logic [NUM_SRC-1:0]   rad_hit;
    logic                 ld_stall;
    logic                 mul_busy;
    logic                 mul_done;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] rae_i;
        logic [REG_AW-1:0] rad_i;
        logic              hit_m;
        logic              hit_w;

        assign rae_i = RAE[i*REG_AW +: REG_AW];
        assign rad_i = RAD[i*REG_AW +: REG_AW];
        assign hit_m = RegWriteM && (rae_i == WA3M) && (rae_i != PC_ADDR);
        assign hit_w = RegWriteW && (rae_i == WA3W) && (rae_i != PC_ADDR);
        // Memory stage holds the younger result, so it wins over writeback.
        assign fwd[2*i +: 2] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
        assign rad_hit[i]    = (rad_i == WA3E);
    end

    assign ld_stall = MemtoRegE && RegWriteE && (WA3E != PC_ADDR) && (|rad_hit);

`ifdef HAZARD_MUL_EN
    if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
        $error("hazard_ctrl: MUL_LAT must be in 1..16");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic       MUL_MULTI = (MUL_LAT > 1);

    mul_state_t state;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulStartE && MUL_MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    // A MulStartE seen here is the held instruction, not a new multiply.
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign mul_busy = (state == BUSY);
    assign mul_done = mul_busy ? (cnt == 4'd0) : (!MUL_MULTI && MulStartE);
`else
    logic unused_mul_inputs;
    localparam int unused_mul_lat = MUL_LAT;

    assign unused_mul_inputs = &{1'b0, MulStartE, clk};
    assign mul_busy          = 1'b0;
    assign mul_done          = 1'b0;
`endif

    always_comb begin
        ForwardE = '0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        MulBusy  = 1'b0;
        MulDoneE = 1'b0;
        if (!reset) begin
            ForwardE = fwd;
            MulBusy  = mul_busy;
            MulDoneE = mul_done;
            if (mul_busy) begin
                // Execute is occupied: freeze the front end, ignore branch and load-use.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (ld_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl; multiply checks build with HAZARD_MUL_EN.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] RAD, RAE;
    logic [3:0] WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, BranchTakenE, MulStartE;
    logic [3:0] ForwardE;
    logic       StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE;

    logic [3:0] ForwardE_1;
    logic       StallF_1, StallD_1, StallE_1, FlushD_1, FlushE_1, MulBusy_1, MulDoneE_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .MUL_LAT(3), .PC_REG(15)) dut (
        .clk(clk), .reset(reset), .RAD(RAD), .RAE(RAE),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MulBusy(MulBusy), .MulDoneE(MulDoneE)
    );

    hazard_ctrl #(.REG_AW(4), .NUM_SRC(2), .MUL_LAT(1), .PC_REG(15)) dut1 (
        .clk(clk), .reset(reset), .RAD(RAD), .RAE(RAE),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardE(ForwardE_1), .StallF(StallF_1), .StallD(StallD_1), .StallE(StallE_1),
        .FlushD(FlushD_1), .FlushE(FlushE_1), .MulBusy(MulBusy_1), .MulDoneE(MulDoneE_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs packed as {StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE}
    function automatic logic [6:0] ctl0();
        return {StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE};
    endfunction

    function automatic logic [6:0] ctl1();
        return {StallF_1, StallD_1, StallE_1, FlushD_1, FlushE_1, MulBusy_1, MulDoneE_1};
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        RAD = '0; RAE = '0; WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; BranchTakenE = 0; MulStartE = 0;

        // Reset forces everything low even with a live forwarding match and branch.
        RAE[3:0] = 4'd3; WA3M = 4'd3; RegWriteM = 1; BranchTakenE = 1;
        #1;
        chk("reset_fwd", ForwardE, 4'b0000);
        chk("reset_ctl", ctl0(), 7'b0000000);
        BranchTakenE = 0;

        next_cycle();
        reset = 1'b0;
        WA3W = 4'd3; RegWriteW = 1;
        #1;
        chk("fwd_m", ForwardE, 4'b0010);
        chk("fwd_m_ctl", ctl0(), 7'b0000000);

        next_cycle();
        RegWriteM = 0;
        #1;
        chk("fwd_w", ForwardE, 4'b0001);

        next_cycle();
        RegWriteM = 1; RAE[3:0] = 4'd15; WA3M = 4'd15; WA3W = 4'd15;
        #1;
        chk("fwd_pc", ForwardE, 4'b0000);

        next_cycle();
        RAE = {4'd7, 4'd7}; WA3M = 4'd7; WA3W = 4'd7;
        #1;
        chk("fwd_both_m", ForwardE, 4'b1010);

        next_cycle();
        RAE = {4'd2, 4'd9}; WA3M = 4'd9; WA3W = 4'd2;
        #1;
        chk("fwd_mixed", ForwardE, 4'b0110);

        // Load-use on operand 1.
        next_cycle();
        RegWriteM = 0; RegWriteW = 0; RAE = '0;
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RAD = {4'd5, 4'd1};
        #1;
        chk("ldu_ctl", ctl0(), 7'b1100100);

        next_cycle();
        RAD = {4'd1, 4'd5};
        #1;
        chk("ldu_op0_ctl", ctl0(), 7'b1100100);

        next_cycle();
        RegWriteE = 0;
        #1;
        chk("ldu_nowrite", ctl0(), 7'b0000000);

        next_cycle();
        RegWriteE = 1; WA3E = 4'd15; RAD = {4'd15, 4'd0};
        #1;
        chk("ldu_pc", ctl0(), 7'b0000000);

        next_cycle();
        MemtoRegE = 0; WA3E = 4'd5; RAD = {4'd5, 4'd1};
        #1;
        chk("ldu_notload", ctl0(), 7'b0000000);

        // Branch overrides a simultaneous load-use.
        next_cycle();
        MemtoRegE = 1; BranchTakenE = 1;
        #1;
        chk("br_over_ldu", ctl0(), 7'b0001100);

        next_cycle();
        MemtoRegE = 0; RegWriteE = 0;
        #1;
        chk("br_only", ctl0(), 7'b0001100);

        next_cycle();
        BranchTakenE = 0;
        #1;
        chk("idle_ctl", ctl0(), 7'b0000000);

`ifdef HAZARD_MUL_EN
        // MUL_LAT=3: two stalled cycles after the start cycle, done in the second.
        next_cycle();
        MulStartE = 1;
        #1;
        chk("mul_start", ctl0(), 7'b0000000);
        chk("mul1_done", ctl1(), 7'b0000001);

        next_cycle();
        MulStartE = 1; BranchTakenE = 1; MemtoRegE = 1; RegWriteE = 1;
        #1;
        chk("mul_busy1", ctl0(), 7'b1110010);
        chk("mul1_again", ctl1(), 7'b0001101);

        next_cycle();
        MulStartE = 0; BranchTakenE = 0; MemtoRegE = 0; RegWriteE = 0;
        #1;
        chk("mul_busy2", ctl0(), 7'b1110011);
        chk("mul1_quiet", ctl1(), 7'b0000000);

        next_cycle();
        #1;
        chk("mul_idle", ctl0(), 7'b0000000);

        // Asynchronous reset mid-multiply.
        next_cycle();
        MulStartE = 1;
        next_cycle();
        MulStartE = 0;
        RAE[3:0] = 4'd4; WA3M = 4'd4; RegWriteM = 1;
        #1;
        chk("rst_pre_busy", ctl0(), 7'b1110010);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_ctl", ctl0(), 7'b0000000);
        chk("rst_async_fwd", ForwardE, 4'b0000);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rst_release", ctl0(), 7'b0000000);
        chk("rst_release_fwd", ForwardE, 4'b0010);
        next_cycle();
        #1;
        chk("rst_after", ctl0(), 7'b0000000);
        RegWriteM = 0;
`else
        // Without the multiply unit, MulStartE has no effect.
        next_cycle();
        MulStartE = 1;
        #1;
        chk("nomul_start", ctl0(), 7'b0000000);
        chk("nomul1_start", ctl1(), 7'b0000000);

        next_cycle();
        #1;
        chk("nomul_hold", ctl0(), 7'b0000000);

        next_cycle();
        MulStartE = 0;
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RAD = {4'd5, 4'd1};
        RAE[3:0] = 4'd6; WA3W = 4'd6; RegWriteW = 1;
        #1;
        chk("nomul_ldu", ctl0(), 7'b1100100);
        chk("nomul_fwd", ForwardE, 4'b0001);
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
